aes_job_arbiter: RTL and testbench

- Shares one AES encrypt/decrypt core between two requesters (ports 0 and 1); the core has a start/done interface and Nk-sized key.
- Grants the core round-robin, issues a start pulse, waits for the core's done, and returns the 128-bit result to the winning requester over a valid/ready response channel.
- Includes a watchdog timeout so a hung core cannot lock out both requesters.
- Sits between the SPI-side command logic and the AES core instance.

---
 rtl/aes_job_arbiter.sv | 154 +++++++++++++++
 tb/tb_aes_job_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_job_arbiter.sv
// Round-robin arbiter sharing one AES core between two requesters, with a
// start/done handshake to the core and a watchdog that aborts hung jobs.
module aes_arb_rsp_lane (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_done,
  input  logic         ld_tmo,
  input  logic         clr,
  input  logic [127:0] result,
  output logic         valid,
  output logic [127:0] data,
  output logic         err
);
  // Done has priority over timeout when both land in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
      err   <= 1'b0;
    end else if (ld_done) begin
      valid <= 1'b1;
      data  <= result;
      err   <= 1'b0;
    end else if (ld_tmo) begin
      valid <= 1'b1;
      data  <= '0;
      err   <= 1'b1;
    end else if (clr) begin
      valid <= 1'b0;
      data  <= '0;
      err   <= 1'b0;
    end
  end
endmodule

module aes_job_arbiter #(
  parameter int TIMEOUT = 1024,
  parameter int CW      = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic         req0_mode,
  input  logic [127:0] req0_data,
  output logic         req0_ready,
  output logic         rsp0_valid,
  output logic [127:0] rsp0_data,
  output logic         rsp0_err,
  input  logic         rsp0_ready,
  input  logic         req1_valid,
  input  logic         req1_mode,
  input  logic [127:0] req1_data,
  output logic         req1_ready,
  output logic         rsp1_valid,
  output logic [127:0] rsp1_data,
  output logic         rsp1_err,
  input  logic         rsp1_ready,
  output logic         core_start,
  output logic         core_mode,
  output logic [127:0] core_data,
  input  logic         core_done,
  input  logic [127:0] core_result,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state, state_nxt;
  logic                last_grant, owner;
  logic [CW-1:0]       wd, wd_inc;
  logic                gnt_vld, gnt_port, timeout, own_ready;
  logic [1:0]          req_valid, rsp_ready, rsp_valid, rsp_err;
  logic [1:0][127:0]   rsp_data;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign own_ready = rsp_ready[owner];
  assign wd_inc    = wd + CW'(1);
  // Fires on the cycle whose increment reaches TIMEOUT-1, so the response
  // lands exactly TIMEOUT cycles after core_start.
  assign timeout   = (wd_inc == CW'(TIMEOUT - 1));

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_port = 1'b0;
    if (state == IDLE) begin
      case (req_valid)
        2'b01:   gnt_vld = 1'b1;
        2'b10:   begin gnt_vld = 1'b1; gnt_port = 1'b1; end
        2'b11:   begin gnt_vld = 1'b1; gnt_port = ~last_grant; end
        default: ;
      endcase
    end
  end

  assign req0_ready = gnt_vld & ~gnt_port;
  assign req1_ready = gnt_vld &  gnt_port;
  assign core_start = (state == ISSUE);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (core_done || timeout) state_nxt = RESP;
      RESP:    if (own_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      wd         <= '0;
      core_mode  <= 1'b0;
      core_data  <= '0;
    end else begin
      state <= state_nxt;
      if (gnt_vld) begin
        owner      <= gnt_port;
        last_grant <= gnt_port;
        core_mode  <= gnt_port ? req1_mode : req0_mode;
        core_data  <= gnt_port ? req1_data : req0_data;
      end
      if (state == ISSUE)     wd <= '0;
      else if (state == WAIT) wd <= wd_inc;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_lane
    logic own;
    assign own = (owner == 1'(p));
    aes_arb_rsp_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .ld_done (own && state == WAIT && core_done),
      .ld_tmo  (own && state == WAIT && timeout),
      .clr     (own && state == RESP && rsp_ready[p]),
      .result  (core_result),
      .valid   (rsp_valid[p]),
      .data    (rsp_data[p]),
      .err     (rsp_err[p])
    );
  end

  assign rsp0_valid = rsp_valid[0];
  assign rsp0_data  = rsp_data[0];
  assign rsp0_err   = rsp_err[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp1_data  = rsp_data[1];
  assign rsp1_err   = rsp_err[1];
endmodule

// File: tb/tb_aes_job_arbiter.sv
// Directed bench for aes_job_arbiter with a 3-cycle core model that can hang.
module tb_aes_job_arbiter;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0, rst = 1'b0;
  logic         req0_valid = 0, req0_mode = 0, req1_valid = 0, req1_mode = 0;
  logic [127:0] req0_data = '0, req1_data = '0;
  logic         req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [127:0] rsp0_data, rsp1_data, core_data, core_result;
  logic         rsp0_ready = 1, rsp1_ready = 1;
  logic         core_start, core_mode, core_done, busy;

  aes_job_arbiter #(.TIMEOUT(16), .CW(5)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_mode(req0_mode), .req0_data(req0_data), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_mode(req1_mode), .req1_data(req1_data), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err), .rsp1_ready(rsp1_ready),
    .core_start(core_start), .core_mode(core_mode), .core_data(core_data),
    .core_done(core_done), .core_result(core_result), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] aes_model(input logic m, input logic [127:0] d);
    if (!m && d == PT) return CT;
    if (m && d == CT)  return PT;
    return d ^ {4{m ? 32'h5a5a5a5a : 32'ha5a5a5a5}};
  endfunction

  // Core model: done pulses 3 cycles after core_start unless hung.
  logic       hang = 0;
  logic [1:0] ccnt;
  logic [127:0] cres;
  assign core_result = cres;
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      ccnt <= 0; core_done <= 0; cres <= '0;
    end else begin
      core_done <= 0;
      if (core_start) begin
        ccnt <= 3; cres <= aes_model(core_mode, core_data);
      end else if (ccnt != 0) begin
        ccnt <= ccnt - 1;
        if (ccnt == 1 && !hang) core_done <= 1;
      end
    end
  end

  // Monitor: grant log, start log, responses, port-1 activity, rsp1 stability.
  int gq[$], gcyc[$], mq[$];
  logic [127:0] r0d[$], r1d[$];
  int r0e[$], r1e[$], r0c[$], r1c[$];
  int starts = 0, start_hi = 0, start_cyc = 0, overlap = 0, p1_act = 0, stab_err = 0;
  int v0_cyc = 0, v1_cyc = 0, hs1_cyc = 0;
  logic job_open = 0, prev_start = 0, prev_v0 = 0, prev_v1 = 0, prev_r1 = 0;
  logic [127:0] prev_d1 = '0;
  always @(negedge clk) begin
    if (rst) begin
      if (req0_ready) begin gq.push_back(0); gcyc.push_back(cyc); end
      if (req1_ready) begin gq.push_back(1); gcyc.push_back(cyc); end
      if (core_start) begin
        start_hi <= start_hi + 1;
        if (!prev_start) begin
          starts <= starts + 1; start_cyc <= cyc; mq.push_back(int'(core_mode));
          if (job_open) overlap <= overlap + 1;
          job_open <= 1;
        end
      end
      if (rsp0_valid && !prev_v0) v0_cyc <= cyc;
      if (rsp1_valid && !prev_v1) v1_cyc <= cyc;
      if (rsp0_valid && rsp0_ready) begin
        r0d.push_back(rsp0_data); r0e.push_back(int'(rsp0_err));
        r0c.push_back(prev_v0 ? v0_cyc : cyc); job_open <= 0;
      end
      if (rsp1_valid && rsp1_ready) begin
        r1d.push_back(rsp1_data); r1e.push_back(int'(rsp1_err));
        r1c.push_back(prev_v1 ? v1_cyc : cyc); job_open <= 0; hs1_cyc <= cyc;
      end
      if (rsp1_valid || rsp1_err || (|rsp1_data) || req1_ready) p1_act <= p1_act + 1;
      if (prev_v1 && !prev_r1 && (!rsp1_valid || rsp1_data != prev_d1)) stab_err <= stab_err + 1;
      prev_start <= core_start; prev_v0 <= rsp0_valid; prev_v1 <= rsp1_valid;
      prev_r1 <= rsp1_ready; prev_d1 <= rsp1_data;
    end else begin
      prev_start <= 0; prev_v0 <= 0; prev_v1 <= 0; prev_r1 <= 0; job_open <= 0;
    end
  end

  task automatic set_req(input int p, input logic v, input logic m, input logic [127:0] d);
    if (p == 0) begin req0_valid = v; req0_mode = m; req0_data = d; end
    else        begin req1_valid = v; req1_mode = m; req1_data = d; end
  endtask

  // Issue n back-to-back jobs on port p, holding each until it is granted.
  task automatic drive(input int p, input int n, input logic m, input logic [127:0] d0);
    int k;
    @(posedge clk); #1;
    for (int j = 0; j < n; j++) begin
      set_req(p, 1'b1, m, d0 + 128'(j));
      k = 0;
      do begin @(negedge clk); k++; end
      while (!(p == 0 ? req0_ready : req1_ready) && k < 200);
      chk($sformatf("req%0d_grant_wait", p), k < 200, 1);
      @(posedge clk); #1;
    end
    set_req(p, 1'b0, 1'b0, '0);
  endtask

  task automatic wait_rsp(input int p, input int n);
    int k = 0;
    while ((p == 0 ? r0d.size() : r1d.size()) < n && k < 500) begin @(negedge clk); k++; end
    chk($sformatf("rsp%0d_wait", p), k < 500, 1);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int b, s, sh, p1, n0, n1, mb, ov, se, k;
    // reset state
    #23;
    chk("rst_busy", busy, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_mode", core_mode, 0);
    chk("rst_core_data", core_data, 0);
    chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    chk("rst_rsp_err", {rsp1_err, rsp0_err}, 0);
    chk("rst_rsp_data", rsp0_data | rsp1_data, 0);
    @(negedge clk); rst = 1;

    // single encrypt on port 0
    b = gq.size(); s = starts; sh = start_hi; p1 = p1_act; n0 = r0d.size();
    drive(0, 1, 1'b0, PT);
    wait_rsp(0, n0 + 1);
    chk("t1_grants", gq.size() - b, 1);
    chk("t1_gport", gq[b], 0);
    chk("t1_start_lat", start_cyc, gcyc[b] + 1);
    chk("t1_start_width", start_hi - sh, 1);
    chk("t1_rsp_lat", r0c[n0], start_cyc + 4);
    chk("t1_data", r0d[n0], CT);
    chk("t1_err", r0e[n0], 0);
    chk("t1_port1_quiet", p1_act - p1, 0);

    // simultaneous requests after reset
    do_reset();
    b = gq.size(); mb = mq.size(); n0 = r0d.size(); n1 = r1d.size();
    fork
      drive(0, 1, 1'b0, PT);
      drive(1, 1, 1'b1, CT);
    join
    wait_rsp(0, n0 + 1); wait_rsp(1, n1 + 1);
    chk("t2_first", gq[b], 0);
    chk("t2_second", gq[b+1], 1);
    chk("t2_mode0", mq[mb], 0);
    chk("t2_mode1", mq[mb+1], 1);
    chk("t2_data0", r0d[n0], CT);
    chk("t2_data1", r1d[n1], PT);
    chk("t2_err1", r1e[n1], 0);

    // continuous contention, 6 jobs
    b = gq.size(); s = starts; ov = overlap; n0 = r0d.size(); n1 = r1d.size();
    fork
      drive(0, 3, 1'b0, 128'h100);
      drive(1, 3, 1'b1, 128'h200);
    join
    wait_rsp(0, n0 + 3); wait_rsp(1, n1 + 3);
    for (int i = 0; i < 6; i++) chk($sformatf("t3_order%0d", i), gq[b+i], i % 2);
    chk("t3_starts", starts - s, 6);
    chk("t3_overlap", overlap - ov, 0);
    chk("t3_data1_last", r1d[n1+2], 128'h202 ^ {4{32'h5a5a5a5a}});

    // watchdog timeout, then normal service
    hang = 1; n0 = r0d.size();
    drive(0, 1, 1'b0, PT);
    wait_rsp(0, n0 + 1);
    chk("t4_tmo_lat", r0c[n0], start_cyc + 16);
    chk("t4_tmo_err", r0e[n0], 1);
    chk("t4_tmo_data", r0d[n0], 0);
    hang = 0;
    drive(0, 1, 1'b1, CT);
    wait_rsp(0, n0 + 2);
    chk("t4_after_data", r0d[n0+1], PT);
    chk("t4_after_err", r0e[n0+1], 0);

    // response backpressure on port 1
    rsp1_ready = 0; n0 = r0d.size(); n1 = r1d.size();
    drive(1, 1, 1'b0, PT);
    k = 0;
    while (!rsp1_valid && k < 100) begin @(negedge clk); k++; end
    chk("t5_rsp1_seen", rsp1_valid, 1);
    b = gq.size(); se = stab_err;
    fork drive(0, 1, 1'b1, CT); join_none
    repeat (10) @(negedge clk);
    chk("t5_no_grant", gq.size() - b, 0);
    chk("t5_held_valid", rsp1_valid, 1);
    chk("t5_held_data", rsp1_data, CT);
    @(posedge clk); #1 rsp1_ready = 1;
    wait_rsp(1, n1 + 1); wait_rsp(0, n0 + 1);
    chk("t5_stable", stab_err - se, 0);
    chk("t5_gport", gq[b], 0);
    chk("t5_grant_after_hs", gcyc[b], hs1_cyc + 1);
    chk("t5_data0", r0d[n0], PT);

    // reset during WAIT
    hang = 1; n0 = r0d.size();
    drive(0, 1, 1'b0, PT);
    repeat (4) @(negedge clk);
    chk("t6_busy_pre", busy, 1);
    #3 rst = 0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_core_data", core_data, 0);
    chk("t6_core_start_mode", {core_start, core_mode}, 0);
    chk("t6_rsp", {rsp0_valid, rsp0_err, rsp1_valid}, 0);
    @(negedge clk); rst = 1; hang = 0;
    repeat (30) @(negedge clk);
    chk("t6_no_rsp", r0d.size() - n0, 0);
    b = gq.size(); n1 = r1d.size();
    fork
      drive(0, 1, 1'b1, CT);
      drive(1, 1, 1'b0, PT);
    join
    wait_rsp(0, n0 + 1); wait_rsp(1, n1 + 1);
    chk("t6_tie_first", gq[b], 0);
    chk("t6_data0", r0d[n0], PT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
